// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the memory-port arbiter: default address/data
//   widths of the memory_unit port, the arbiter state encodings, the memory
//   func codes, and a small wrap-around increment helper for the
//   round-robin pointer.
package mem_arbiter_pkg;

    localparam int MA_ADDR_W = 16;
    localparam int MA_DATA_W = 64;

    // Number of consecutive WAIT_BUSY cycles with is_ready still high after
    // which the memory is taken to have completed with zero latency.
    localparam int MA_WB_ZL_CYC = 2;

    typedef enum logic [2:0] {
        MA_IDLE      = 3'd0,
        MA_ISSUE     = 3'd1,
        MA_WAIT_BUSY = 3'd2,
        MA_WAIT_DONE = 3'd3,
        MA_RESP      = 3'd4
    } ma_state_e;

    // memory_unit func codes
    localparam logic [1:0] MEM_FUNC_READ  = 2'd0;
    localparam logic [1:0] MEM_FUNC_WRITE = 2'd1;
    localparam logic [1:0] MEM_FUNC_RSVD2 = 2'd2;
    localparam logic [1:0] MEM_FUNC_RSVD3 = 2'd3;

    // (idx + 1) mod n, for idx in [0, n-1]
    function automatic int ma_wrap_inc(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// mem_arbiter_rr_picker
//   Combinational round-robin priority encoder. Starting at i_ptr and
//   walking upward with wrap-around, returns the first requester with its
//   request bit set as a one-hot pick.
//   Ports:
//     i_req   - request vector
//     i_ptr   - index with highest priority this cycle
//     o_pick  - one-hot winner (0 if none)
//     o_valid - at least one request present
module mem_arbiter_rr_picker #(
    parameter int N_REQ = 3,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_pick,
    output logic             o_valid
);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_pick  = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % N_REQ);
            if (!o_valid && i_req[w_idx]) begin
                o_pick[w_idx] = 1'b1;
                o_valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Request/grant arbiter for the single memory_unit port. Picks one
//   requester (round-robin, or the locked owner), registers its command onto
//   the memory port, pulses execute, follows the is_ready handshake, latches
//   read data and returns a one-cycle done pulse to the owner.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   MA_IDLE      | no transaction; arbitrate when memory is ready
//   MA_ISSUE     | mem_execute pulsed for this single cycle
//   MA_WAIT_BUSY | waiting for is_ready to drop (or zero-latency timeout)
//   MA_WAIT_DONE | waiting for is_ready to return; latch read data
//   MA_RESP      | done pulse to owner; update lock / rr pointer
//
//   Ports:
//     i_clk, i_rst               - clock, async active-high reset
//     i_req / i_req_lock         - per-requester request level / lock
//     i_req_func/addr1/addr2/wdata - packed per-requester commands
//     o_grant / o_done           - one-hot owner / completion pulse
//     o_rdata1 / o_rdata2        - read data latched at completion
//     o_mem_*                    - command to memory_unit
//     i_mem_ready, i_mem_read_data1/2 - memory_unit status and data
//     o_busy                     - transaction in flight or grant held
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = MA_ADDR_W,
    parameter int DATA_W = MA_DATA_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_req_lock,
    input  logic [2*N_REQ-1:0]      i_req_func,
    input  logic [ADDR_W*N_REQ-1:0] i_req_addr1,
    input  logic [ADDR_W*N_REQ-1:0] i_req_addr2,
    input  logic [DATA_W*N_REQ-1:0] i_req_wdata,
    output logic [N_REQ-1:0]        o_grant,
    output logic [N_REQ-1:0]        o_done,
    output logic [DATA_W-1:0]       o_rdata1,
    output logic [DATA_W-1:0]       o_rdata2,
    output logic [1:0]              o_mem_func,
    output logic                    o_mem_execute,
    output logic [ADDR_W-1:0]       o_mem_address1,
    output logic [ADDR_W-1:0]       o_mem_address2,
    output logic [DATA_W-1:0]       o_mem_write_data,
    input  logic                    i_mem_ready,
    input  logic [DATA_W-1:0]       i_mem_read_data1,
    input  logic [DATA_W-1:0]       i_mem_read_data2,
    output logic                    o_busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    ma_state_e          r_state;
    ma_state_e          w_state_nxt;

    logic [N_REQ-1:0]   r_grant;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic               r_locked;
    logic [1:0]         r_wb_cnt;
    logic [1:0]         r_mem_func;
    logic [ADDR_W-1:0]  r_mem_address1;
    logic [ADDR_W-1:0]  r_mem_address2;
    logic [DATA_W-1:0]  r_mem_write_data;
    logic [DATA_W-1:0]  r_rdata1;
    logic [DATA_W-1:0]  r_rdata2;

    logic [N_REQ-1:0]   w_pick;
    logic               w_pick_valid;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_issue;
    logic               w_release;
    logic               w_latch;
    logic               w_resp;
    logic               w_wb_load;
    logic               w_wb_dec;
    logic [PTR_W-1:0]   w_sel;
    logic [N_REQ-1:0]   w_sel_oh;
    logic [1:0]         w_func;
    logic [ADDR_W-1:0]  w_addr1;
    logic [ADDR_W-1:0]  w_addr2;
    logic [DATA_W-1:0]  w_wdata;

    mem_arbiter_rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .i_req   (i_req),
        .i_ptr   (r_rr_ptr),
        .o_pick  (w_pick),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = PTR_W'(i);
            end
        end
    end

    // Command mux for the selected requester
    always_comb begin
        w_func  = '0;
        w_addr1 = '0;
        w_addr2 = '0;
        w_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == PTR_W'(i)) begin
                w_func  = i_req_func[2*i +: 2];
                w_addr1 = i_req_addr1[ADDR_W*i +: ADDR_W];
                w_addr2 = i_req_addr2[ADDR_W*i +: ADDR_W];
                w_wdata = i_req_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    assign w_sel_oh = N_REQ'(1) << w_sel;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= MA_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_issue       = 1'b0;
        w_release     = 1'b0;
        w_latch       = 1'b0;
        w_resp        = 1'b0;
        w_wb_load     = 1'b0;
        w_wb_dec      = 1'b0;
        w_sel         = r_owner;
        o_mem_execute = 1'b0;
        o_done        = '0;

        case (r_state)
            MA_IDLE: begin
                // A locked owner that has dropped its request gives up the
                // port; arbitration among the others proceeds this cycle.
                if (r_locked && !i_req[r_owner]) begin
                    w_release = 1'b1;
                end
                if (r_locked && i_req[r_owner]) begin
                    if (i_mem_ready) begin
                        w_issue = 1'b1;
                        w_sel   = r_owner;
                    end
                end else if (i_mem_ready && w_pick_valid) begin
                    w_issue = 1'b1;
                    w_sel   = w_pick_idx;
                end
                if (w_issue) begin
                    w_state_nxt = MA_ISSUE;
                end
            end
            MA_ISSUE: begin
                o_mem_execute = 1'b1;
                w_wb_load     = 1'b1;
                w_state_nxt   = MA_WAIT_BUSY;
            end
            MA_WAIT_BUSY: begin
                if (!i_mem_ready) begin
                    w_state_nxt = MA_WAIT_DONE;
                end else if (r_wb_cnt == 2'd0) begin
                    // memory never went busy: data already valid
                    w_latch     = 1'b1;
                    w_state_nxt = MA_RESP;
                end else begin
                    w_wb_dec = 1'b1;
                end
            end
            MA_WAIT_DONE: begin
                if (i_mem_ready) begin
                    w_latch     = 1'b1;
                    w_state_nxt = MA_RESP;
                end
            end
            MA_RESP: begin
                o_done      = r_grant;
                w_resp      = 1'b1;
                w_state_nxt = MA_IDLE;
            end
            default: begin
                w_state_nxt = MA_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant          <= '0;
            r_owner          <= '0;
            r_rr_ptr         <= '0;
            r_locked         <= 1'b0;
            r_wb_cnt         <= '0;
            r_mem_func       <= '0;
            r_mem_address1   <= '0;
            r_mem_address2   <= '0;
            r_mem_write_data <= '0;
            r_rdata1         <= '0;
            r_rdata2         <= '0;
        end else begin
            if (w_issue) begin
                r_owner          <= w_sel;
                r_grant          <= w_sel_oh;
                r_mem_func       <= w_func;
                r_mem_address1   <= w_addr1;
                r_mem_address2   <= w_addr2;
                r_mem_write_data <= w_wdata;
            end else if (w_release) begin
                r_grant <= '0;
            end

            if (w_release) begin
                r_locked <= 1'b0;
            end

            if (w_wb_load) begin
                r_wb_cnt <= 2'(MA_WB_ZL_CYC - 1);
            end else if (w_wb_dec) begin
                r_wb_cnt <= r_wb_cnt - 2'd1;
            end

            if (w_latch) begin
                r_rdata1 <= i_mem_read_data1;
                r_rdata2 <= i_mem_read_data2;
            end

            if (w_resp) begin
                r_locked <= i_req_lock[r_owner];
                if (!i_req_lock[r_owner]) begin
                    r_grant  <= '0;
                    r_rr_ptr <= PTR_W'(ma_wrap_inc(int'(r_owner), N_REQ));
                end
            end
        end
    end

    assign o_grant          = r_grant;
    assign o_rdata1         = r_rdata1;
    assign o_rdata2         = r_rdata2;
    assign o_mem_func       = r_mem_func;
    assign o_mem_address1   = r_mem_address1;
    assign o_mem_address2   = r_mem_address2;
    assign o_mem_write_data = r_mem_write_data;
    assign o_busy           = (r_state != MA_IDLE) || (|r_grant);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single memory_unit port between up to N_REQ requesters: the traversal unit (req 0), the Nock execute module (req 1) and a spare port (req 2, e.g. a future GC/alloc unit).
- Replaces the static select-driven memory mux with request/grant arbitration.
- Sequences each memory transaction via the memory_unit's execute/is_ready handshake and returns read data plus a one-cycle done pulse to the winner.
- Supports a lock so a requester keeps ownership across a multi-transaction sequence.

Parameters:
- N_REQ, 3, number of requesters (2..4).
- ADDR_W, `memory_addr_width, address width.
- DATA_W, `memory_data_width, data word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held until that requester's done.
- req_lock  in  N_REQ  keep grant after the current transaction completes.
- req_func  in  2*N_REQ  packed memory func per requester (slice i at [2i+1:2i]).
- req_addr1  in  ADDR_W*N_REQ  packed address1.
- req_addr2  in  ADDR_W*N_REQ  packed address2.
- req_wdata  in  DATA_W*N_REQ  packed write_data.
- grant  out  N_REQ  one-hot owner; 0 when idle.
- done  out  N_REQ  one-cycle completion pulse to the owner.
- rdata1  out  DATA_W  read_data1 latched at completion.
- rdata2  out  DATA_W  read_data2 latched at completion.
- mem_func  out  2  to memory_unit.
- mem_execute  out  1  to memory_unit; one-cycle pulse.
- mem_address1  out  ADDR_W  to memory_unit.
- mem_address2  out  ADDR_W  to memory_unit.
- mem_write_data  out  DATA_W  to memory_unit.
- mem_ready  in  1  memory_unit is_ready.
- mem_read_data1  in  DATA_W  memory_unit read_data1.
- mem_read_data2  in  DATA_W  memory_unit read_data2.
- busy  out  1  state != IDLE or any grant held.

Behaviour:
- Reset (async, active-high): state=IDLE, grant=0, done=0, mem_execute=0, mem_* outputs=0, rdata1/2=0, rr_ptr=0, locked=0. Reset mid-transaction drops the transaction; no done is issued.
- State machine: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE arbitration:
  - If locked and req[owner]=1 and mem_ready=1: re-issue for owner.
  - Otherwise pick the first requester with req=1 searching from rr_ptr upward with wrap-around (N_REQ-1 -> 0). This happens only when mem_ready=1 and not locked.
  - On a pick: register that requester's func, addr1, addr2 and wdata into the mem_* outputs; set grant one-hot; go to ISSUE.
- Locked owner dropping req: if locked and req[owner]=0 in IDLE, release the lock (grant=0, locked=0) and arbitrate in the same cycle.
- ISSUE: mem_execute=1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for mem_ready=0, then go to WAIT_DONE. If mem_ready stays 1 for 2 cycles, treat the transaction as zero-latency and go to RESP.
- WAIT_DONE: on mem_ready=1, latch mem_read_data1/2 into rdata1/2 and go to RESP.
- RESP:
  - done[owner]=1 for one cycle.
  - locked <= req_lock[owner].
  - If not locked, grant <= 0 and rr_ptr <= owner+1 (mod N_REQ).
  - Go to IDLE.
- Requester rule: req is deasserted on the edge where done=1 is sampled. It may be re-asserted from the next cycle.
- mem_* outputs hold their values from ISSUE through RESP; they are unchanged in IDLE.
- Latency, zero contention: req high in cycle t gives ISSUE at t+1. done = t+1 + 2 + memory busy cycles + 1.
- Request inputs change only the next issue, never a transaction in flight.
- A req_lock on a non-owner has no effect.
- Ignore req bits at index >= N_REQ.

Decomposition:
- Add to memory_unit.vh: state encodings (MA_IDLE..MA_RESP) and the func codes already used by the memory unit.
- One sub-module, rr_picker: combinational round-robin priority encoder (req, rr_ptr) -> one-hot pick plus valid.

Test Plan:
1. Single request: req=3'b001, func=read, addr1=5. Expect one mem_execute pulse with mem_address1=5, done[0] once, rdata1 = mem[5], grant back to 0.
2. Contention: req=3'b111 held, rr_ptr=0. Expect grant order 0,1,2,0 and exactly one done per transaction.
3. Lock: req0 with req_lock=1 for 3 transactions while req1 is pending. Expect grant[0] for all 3; req1 granted only after req0 drops req with lock released.
4. Wrap-around: rr_ptr=2 after serving req1, then req=3'b011. Expect 0 granted before 1.
5. Reset mid-op: assert rst in WAIT_DONE. Expect grant=0, mem_execute=0, no done; the next req0 completes normally.
6. Write then read: req1 writes 64'hDEAD_BEEF to addr 9, then req2 reads addr 9. Expect rdata1=64'hDEAD_BEEF, done[2] once.
